// File: rtl/rom_loader_pkg.sv
// Shared constants, state encoding and per-state output decode for the boot ROM loader.
package rom_loader_pkg;

  localparam int LEN_W  = 16;
  localparam int CSUM_W = 8;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  localparam logic [ADDR_W-1:0] ROM_START = 16'h0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  typedef struct packed {
    logic inReady;
    logic wrReq;
    logic writeProtect;
    logic cpuHalt;
    logic busy;
    logic error;
  } ctrl_t;

  // The ROM stays writable only while a load is in flight; the CPU stays halted
  // through ERROR so a partial image can never run.
  function automatic ctrl_t decodeCtrl(state_e s);
    ctrl_t c;
    c = '{inReady: 1'b0, wrReq: 1'b0, writeProtect: 1'b1,
          cpuHalt: 1'b0, busy: 1'b0, error: 1'b0};
    case (s)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK: begin
        c.inReady      = 1'b1;
        c.writeProtect = 1'b0;
        c.cpuHalt      = 1'b1;
        c.busy         = 1'b1;
      end
      S_WRITE: begin
        c.wrReq        = 1'b1;
        c.writeProtect = 1'b0;
        c.cpuHalt      = 1'b1;
        c.busy         = 1'b1;
      end
      S_ERROR: begin
        c.cpuHalt = 1'b1;
        c.error   = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rom_loader.sv
// Boot-time ROM programming controller: parses a length-prefixed, checksummed byte
// stream and writes it word by word into the ROM write port.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int                DEPTH = 32768,
  parameter logic [ADDR_W-1:0] BASE  = ROM_START
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  input  logic              wr_ack,
  output logic              write_protect,
  output logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_e              state_q, state_d;
  ctrl_t               ctrl_q;
  logic                done_q;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic [CSUM_W-1:0]   csum_q, csum_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0]   wr_data_q, wr_data_d;

  logic                xfer;
  logic [LEN_W-1:0]    lenNew;
  logic [LEN_W-1:0]    countInc;
  logic                lenBad;

  assign xfer     = in_valid & ctrl_q.inReady;
  assign lenNew   = {len_q[LEN_W-1:8], in_data};
  assign countInc = count_q + 16'd1;
  assign lenBad   = (lenNew == '0) || (int'(lenNew) > DEPTH);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    csum_d    = csum_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d   = S_LEN_HI;
          count_d   = '0;
          csum_d    = '0;
          wr_addr_d = BASE;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d   = {in_data, len_q[7:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d   = lenNew;
          state_d = lenBad ? S_ERROR : S_DATA_HI;
        end
      end
      // Length bytes are excluded from the checksum; only payload bytes count.
      S_DATA_HI: begin
        if (xfer) begin
          wr_data_d[15:8] = in_data;
          csum_d          = csum_q + in_data;
          state_d         = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (xfer) begin
          wr_data_d[7:0] = in_data;
          csum_d         = csum_q + in_data;
          state_d        = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wr_ack) begin
          wr_addr_d = wr_addr_q + 16'd1;
          count_d   = countInc;
          state_d   = (countInc == len_q) ? S_CHECK : S_DATA_HI;
        end
      end
      S_CHECK: begin
        if (xfer) begin
          state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q
  // without any combinational path from in_valid or wr_ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ctrl_q    <= decodeCtrl(S_IDLE);
      done_q    <= 1'b0;
      len_q     <= '0;
      count_q   <= '0;
      csum_q    <= '0;
      wr_addr_q <= BASE;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= decodeCtrl(state_d);
      done_q    <= (state_d == S_DONE) && (state_q != S_DONE);
      len_q     <= len_d;
      count_q   <= count_d;
      csum_q    <= csum_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign in_ready      = ctrl_q.inReady;
  assign wr_req        = ctrl_q.wrReq;
  assign write_protect = ctrl_q.writeProtect;
  assign cpu_halt      = ctrl_q.cpuHalt;
  assign busy          = ctrl_q.busy;
  assign error         = ctrl_q.error;
  assign done          = done_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: a byte driver, an ack responder and a monitor
// that checks every ROM write and every done/error outcome against queued expectations.
module tb_rom_loader;

  localparam logic [15:0] BASE = 16'h2000;
  localparam int OUT_DONE = 1;
  localparam int OUT_ERR  = 2;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wrExp_t;

  typedef logic [7:0] byteQ_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        write_protect;
  logic        cpu_halt;
  logic        busy;
  logic        done;
  logic        error;

  logic respAck = 1'b0;
  logic spurAck = 1'b0;
  int   ackDelay = 0;
  int   ackCnt = 0;
  logic prevErr = 1'b0;

  int checks = 0;
  int failures = 0;

  wrExp_t     expWr[$];
  int         outQ[$];
  logic [7:0] txQ[$];

  byteQ_t streamGood;
  byteQ_t streamBad;
  byteQ_t streamTwo;
  byteQ_t streamLenZero;
  byteQ_t streamLenBig;

  assign wr_ack = respAck | spurAck;

  rom_loader #(.DEPTH(32768), .BASE(BASE)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ack(wr_ack),
    .write_protect(write_protect),
    .cpu_halt(cpu_halt),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic failNote(input string name, input logic [31:0] actual);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got %0h expected none", name, actual);
  endtask

  // Byte source: keeps in_valid high while bytes remain, consumes one per accepting edge.
  initial begin
    in_valid = 1'b0;
    in_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (txQ.size() > 0) begin
        in_valid = 1'b1;
        in_data  = txQ[0];
        if (in_ready) begin
          @(posedge clk);
          #1;
          void'(txQ.pop_front());
        end
      end else begin
        in_valid = 1'b0;
      end
    end
  end

  // Write-port model: acknowledges each request after ackDelay waiting cycles.
  always @(posedge clk) begin
    #1;
    if (wr_req) begin
      if (ackCnt >= ackDelay) begin
        respAck = 1'b1;
        ackCnt  = 0;
      end else begin
        respAck = 1'b0;
        ackCnt++;
      end
    end else begin
      respAck = 1'b0;
      ackCnt  = 0;
    end
  end

  // Monitor: every write-request cycle must show the next expected word, and
  // every done pulse / error rise must match the next expected outcome.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_req) begin
        if (expWr.size() == 0) begin
          failNote("unexpectedWrite", {wr_addr, wr_data});
        end else begin
          checkOutput("wrAddr", 32'(wr_addr), 32'(expWr[0].addr));
          checkOutput("wrData", 32'(wr_data), 32'(expWr[0].data));
          checkOutput("inReadyInWrite", 32'(in_ready), 32'd0);
          if (wr_ack) void'(expWr.pop_front());
        end
      end
      if (done || (error && !prevErr)) begin
        checkOutput("doneErrExclusive", 32'(done && error), 32'd0);
        if (outQ.size() == 0) begin
          failNote("unexpectedOutcome", {30'd0, error, done});
        end else begin
          checkOutput("outcome", done ? OUT_DONE : OUT_ERR, outQ[0]);
          void'(outQ.pop_front());
        end
      end
    end
    prevErr = error;
  end

  task automatic applyStimulus(input byteQ_t bytes);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    foreach (bytes[i]) txQ.push_back(bytes[i]);
  endtask

  task automatic expectWrites3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    expWr.push_back('{addr: BASE,         data: a});
    expWr.push_back('{addr: BASE + 16'd1, data: b});
    expWr.push_back('{addr: BASE + 16'd2, data: c});
  endtask

  task automatic waitOutcome(input string name);
    int i;
    for (i = 0; i < 500; i++) begin
      if (outQ.size() == 0) break;
      @(posedge clk);
    end
    if (outQ.size() != 0) begin
      failNote({name, "_timeout"}, 32'(outQ.size()));
      outQ.delete();
    end
    @(posedge clk);
    #1;
    checkOutput({name, "_writesDrained"}, 32'(expWr.size()), 32'd0);
    expWr.delete();
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1 reset = 1'b1;
    txQ.delete();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic found;
    streamGood    = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hBF};
    streamBad     = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h12};
    streamTwo     = '{8'h00, 8'h02, 8'h55, 8'hAA, 8'h01, 8'h02, 8'h02};
    streamLenZero = '{8'h00, 8'h00};
    streamLenBig  = '{8'h80, 8'h01};

    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstWriteProtect", 32'(write_protect), 32'd1);
    checkOutput("rstCpuHalt", 32'(cpu_halt), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstInReady", 32'(in_ready), 32'd0);
    checkOutput("rstWrReq", 32'(wr_req), 32'd0);
    checkOutput("rstWrAddr", 32'(wr_addr), 32'(BASE));
    checkOutput("rstWrData", 32'(wr_data), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstError", 32'(error), 32'd0);
    reset = 1'b0;

    $display("[TB] good three-word load, immediate ack");
    ackDelay = 0;
    expectWrites3(16'h1234, 16'hABCD, 16'h0001);
    outQ.push_back(OUT_DONE);
    applyStimulus(streamGood);
    checkOutput("loadBusy", 32'(busy), 32'd1);
    checkOutput("loadWriteProtect", 32'(write_protect), 32'd0);
    checkOutput("loadCpuHalt", 32'(cpu_halt), 32'd1);
    waitOutcome("good");
    checkOutput("goodWriteProtect", 32'(write_protect), 32'd1);
    checkOutput("goodCpuHalt", 32'(cpu_halt), 32'd0);
    checkOutput("goodDoneCleared", 32'(done), 32'd0);
    checkOutput("goodError", 32'(error), 32'd0);

    $display("[TB] bad checksum");
    expectWrites3(16'h1234, 16'hABCD, 16'h0001);
    outQ.push_back(OUT_ERR);
    applyStimulus(streamBad);
    waitOutcome("badCsum");
    checkOutput("badError", 32'(error), 32'd1);
    checkOutput("badCpuHalt", 32'(cpu_halt), 32'd1);
    checkOutput("badWriteProtect", 32'(write_protect), 32'd1);

    $display("[TB] zero and oversized length");
    outQ.push_back(OUT_ERR);
    applyStimulus(streamLenZero);
    waitOutcome("lenZero");
    checkOutput("lenZeroError", 32'(error), 32'd1);
    outQ.push_back(OUT_ERR);
    applyStimulus(streamLenBig);
    waitOutcome("lenBig");
    checkOutput("lenBigError", 32'(error), 32'd1);

    $display("[TB] delayed ack with in_valid held high");
    ackDelay = 5;
    expWr.push_back('{addr: BASE,         data: 16'h55AA});
    expWr.push_back('{addr: BASE + 16'd1, data: 16'h0102});
    outQ.push_back(OUT_DONE);
    applyStimulus(streamTwo);
    waitOutcome("slowAck");
    checkOutput("slowAckError", 32'(error), 32'd0);

    $display("[TB] reset during second word write");
    expectWrites3(16'h1234, 16'hABCD, 16'h0001);
    outQ.push_back(OUT_DONE);
    applyStimulus(streamGood);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wr_req && wr_addr == BASE + 16'd1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) failNote("word2Timeout", 32'(wr_addr));
    @(posedge clk);
    #1 reset = 1'b1;
    txQ.delete();
    @(posedge clk);
    #1;
    checkOutput("midRstWrReq", 32'(wr_req), 32'd0);
    checkOutput("midRstWriteProtect", 32'(write_protect), 32'd1);
    checkOutput("midRstWrAddr", 32'(wr_addr), 32'(BASE));
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstCpuHalt", 32'(cpu_halt), 32'd0);
    expWr.delete();
    outQ.delete();
    reset = 1'b0;
    ackDelay = 0;
    expectWrites3(16'h1234, 16'hABCD, 16'h0001);
    outQ.push_back(OUT_DONE);
    applyStimulus(streamGood);
    waitOutcome("afterRst");

    $display("[TB] start pulsed mid-load");
    ackDelay = 2;
    expWr.push_back('{addr: BASE,         data: 16'h55AA});
    expWr.push_back('{addr: BASE + 16'd1, data: 16'h0102});
    outQ.push_back(OUT_DONE);
    applyStimulus(streamTwo);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (wr_req) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) failNote("wrReqTimeout", 32'(wr_req));
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput("midStartBusy", 32'(busy), 32'd1);
    waitOutcome("midStart");

    $display("[TB] spurious ack in idle");
    pulseReset();
    spurAck = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("spurBusy", 32'(busy), 32'd0);
    checkOutput("spurWrReq", 32'(wr_req), 32'd0);
    checkOutput("spurInReady", 32'(in_ready), 32'd0);
    checkOutput("spurWrAddr", 32'(wr_addr), 32'(BASE));
    checkOutput("spurWriteProtect", 32'(write_protect), 32'd1);
    spurAck = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("finalOutcomesLeft", 32'(outQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
